dat_serializer: RTL
===================

Name: dat_serializer

Overview:
- Upstream feeder for the serial-pattern counter stage: converts parallel words into the single-bit DAT stream that stage samples on clk.
- Buffers up to DEPTH words in an internal FIFO behind a valid/ready handshake.
- Shifts each word out one bit per clock, back-to-back with no gap while words are queued.
- Flags every bit actually driven and the last bit of every word.

Parameters:
- WIDTH, 8: bits per word.
- DEPTH, 4: FIFO entries (power of two, >=2).
- MSB_FIRST, 1: 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
- IDLE_LEVEL, 0: DAT value whenever no word is being shifted.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- in_data  in  WIDTH  word to enqueue.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  FIFO can accept a word this cycle.
- DAT  out  1  registered serial output bit.
- dat_valid  out  1  DAT carries a data bit (not idle fill).
- word_done  out  1  one-cycle pulse while DAT carries the last bit of a word.
- fifo_count  out  $clog2(DEPTH+1)  number of queued words, excluding the word being shifted.
- busy  out  1  high when state is SHIFT or fifo_count is nonzero.

Behaviour:
- Reset behaviour:
  - One clock is used; reset is synchronous and active-high.
  - At a rising edge with reset=1: FIFO pointers and count clear, state goes to IDLE, shift register and bit counter clear.
  - Outputs after reset: DAT=IDLE_LEVEL, dat_valid=0, word_done=0, fifo_count=0, busy=0.
  - in_ready is 1 from the first cycle after reset.
  - A reset mid-word aborts the word immediately; queued words are discarded.
- FIFO:
  - Push occurs when in_valid && in_ready at an edge.
  - in_ready = (fifo_count < DEPTH), combinational from the registered count.
  - When full, in_ready=0, even if a pop occurs in the same cycle (no push-through when full).
  - A push and a pop in the same edge leave the count unchanged.
  - Pointers wrap modulo DEPTH.
  - Data is ordered first in, first out.
- State machine: IDLE, SHIFT.
  - IDLE, fifo_count==0: remain in IDLE; DAT=IDLE_LEVEL, dat_valid=0.
  - IDLE, fifo_count>0: at the edge, pop the head word into the shift register, set bit_cnt=0, go to SHIFT. The first bit appears on DAT after this edge, with dat_valid=1.
  - SHIFT, bit_cnt<WIDTH-1: at each edge, drive the next bit and increment bit_cnt.
  - SHIFT, bit_cnt==WIDTH-1: the current cycle is the last bit, and word_done=1 during it.
    - At the edge, if fifo_count>0, or a push lands in that same edge while the FIFO was empty, pop and load the next word; its first bit follows with zero gap and the state stays SHIFT.
    - Otherwise go to IDLE: DAT returns to IDLE_LEVEL and dat_valid=0.
- Latency: a word pushed at edge N into an empty, idle block shows its first bit after edge N+1. Its last bit is visible during the cycle following edge N+WIDTH.
- Bit order: with MSB_FIRST=1, bit WIDTH-1 first. With MSB_FIRST=0, bit 0 first.
- DAT, dat_valid and word_done are registered outputs, glitch-free for the downstream stage.
- in_data is ignored when in_valid=0; X on in_data while in_valid=0 must not propagate.

Test Plan:
- Reset held 2 cycles, then push 8'hA5 once -> after 1 cycle of latency, DAT = 1,0,1,0,0,1,0,1 on consecutive cycles; dat_valid high for exactly 8 cycles; word_done high only on the 8th bit; then DAT=0, busy=0.
- Push 8'hFF then 8'h00 on consecutive edges -> 16 contiguous dat_valid cycles, DAT = eight 1s then eight 0s, word_done pulses at bits 8 and 16, no idle cycle between words.
- Push 1 word, then hold in_valid with 8'h11,8'h22,8'h33,8'h44,8'h55 while the first word shifts:
  - fifo_count climbs to 4 and in_ready drops to 0; 8'h55 is stalled.
  - 8'h55 is accepted on the edge after the next pop.
  - The output order is 11,22,33,44,55.
- MSB_FIRST=0, push 8'h01 -> first DAT bit 1, followed by seven 0s.
- Assert reset for 1 cycle at bit 3 of a word, with 2 words queued -> next cycle DAT=IDLE_LEVEL, dat_valid=0, fifo_count=0, in_ready=1; queued words are never emitted.
- Serialize 8'b01010110 into the downstream pattern-counter stage -> downstream counter matches the value expected for that bit pattern; DAT is stable across every sampling edge.

Source files
------------

// File: rtl/dat_serializer_if.sv
// Handshake and serial-output bundle for dat_serializer.
// master: word producer / serial consumer side; slave: the serializer itself.
interface dat_serializer_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
);
   localparam int CNTW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;
   logic             DAT;
   logic             dat_valid;
   logic             word_done;
   logic [CNTW-1:0]  fifo_count;
   logic             busy;

   modport master (
      output in_data, in_valid,
      input  in_ready, DAT, dat_valid, word_done, fifo_count, busy
   );

   modport slave (
      input  in_data, in_valid,
      output in_ready, DAT, dat_valid, word_done, fifo_count, busy
   );
endinterface

// File: rtl/dat_serializer.sv
// Parallel-to-serial feeder: DEPTH-entry FIFO behind valid/ready, then a
// shift register emitting one bit per clock with back-to-back words.
module dat_serializer #(
   parameter int   WIDTH      = 8,
   parameter int   DEPTH      = 4,
   parameter bit   MSB_FIRST  = 1'b1,
   parameter logic IDLE_LEVEL = 1'b0
) (
   input logic             clk,
   input logic             reset,
   dat_serializer_if.slave bus
);
   localparam int CNTW = $clog2(DEPTH + 1);
   localparam int PW   = $clog2(DEPTH);
   localparam int CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNTW-1:0] DEPTH_C  = CNTW'(DEPTH);
   localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic {S_IDLE, S_SHIFT} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNTW-1:0]  count_q, count_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
   logic             dat_q, dat_d;
   logic             dat_valid_q, dat_valid_d;
   logic             word_done_q, word_done_d;

   logic             in_ready_s;
   logic             push;
   logic             pop;
   logic             last_bit;
   logic [WIDTH-1:0] load_word;

   assign in_ready_s     = (count_q < DEPTH_C);
   assign push           = bus.in_valid && in_ready_s;
   assign last_bit       = (state_q == S_SHIFT) && (bit_cnt_q == CNT_LAST);
   // An empty FIFO can only reach the loader when a push lands on the
   // last-bit edge; that word is taken straight from the input bus.
   assign load_word      = (count_q != '0) ? mem_q[rd_ptr_q] : bus.in_data;

   assign bus.in_ready   = in_ready_s;
   assign bus.DAT        = dat_q;
   assign bus.dat_valid  = dat_valid_q;
   assign bus.word_done  = word_done_q;
   assign bus.fifo_count = count_q;
   assign bus.busy       = (state_q == S_SHIFT) || (count_q != '0);

   // Next-state, FIFO bookkeeping and serial output selection.
   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      shreg_d     = shreg_q;
      bit_cnt_d   = bit_cnt_q;
      dat_d       = IDLE_LEVEL;
      dat_valid_d = 1'b0;
      pop         = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (count_q != '0) pop = 1'b1;
         end
         S_SHIFT: begin
            if (last_bit) begin
               if ((count_q != '0) || push) pop = 1'b1;
               else                         state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (pop) begin
         state_d     = S_SHIFT;
         bit_cnt_d   = '0;
         dat_valid_d = 1'b1;
         if (MSB_FIRST) begin
            dat_d   = load_word[WIDTH-1];
            shreg_d = load_word << 1;
         end else begin
            dat_d   = load_word[0];
            shreg_d = load_word >> 1;
         end
      end else if ((state_q == S_SHIFT) && !last_bit) begin
         bit_cnt_d   = bit_cnt_q + 1'b1;
         dat_valid_d = 1'b1;
         if (MSB_FIRST) begin
            dat_d   = shreg_q[WIDTH-1];
            shreg_d = shreg_q << 1;
         end else begin
            dat_d   = shreg_q[0];
            shreg_d = shreg_q >> 1;
         end
      end

      word_done_d = dat_valid_d && (bit_cnt_d == CNT_LAST);

      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // State, pointer and registered-output update with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         shreg_q     <= '0;
         bit_cnt_q   <= '0;
         dat_q       <= IDLE_LEVEL;
         dat_valid_q <= 1'b0;
         word_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         shreg_q     <= shreg_d;
         bit_cnt_q   <= bit_cnt_d;
         dat_q       <= dat_d;
         dat_valid_q <= dat_valid_d;
         word_done_q <= word_done_d;
      end
   end

   // FIFO storage write; contents need no reset since pointers gate reads.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= bus.in_data;
   end
endmodule
